mux_tree_pipe: RTL



---
 rtl/mux_tree_pkg.sv | 23 ++
 rtl/mux_tree_stage.sv | 79 +++++++
 rtl/mux_tree_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mux_tree_pkg.sv
// Shared width helpers and payload control type for the pipelined N:1 selector tree.
package mux_tree_pkg;

  typedef struct packed {
    logic valid;
    logic err;
  } stage_ctl_t;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int width_min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int stage_count(input int lvls, input int stage_lvls);
    int c;
    c = (lvls + stage_lvls - 1) / stage_lvls;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline slice of the selector tree: reduces 2^IN_L candidates by RED levels
// (LSB-first on the remaining sel bits) and registers the survivors with their control.
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter int DW   = 64,
  parameter int SW   = 5,
  parameter int IN_L = 2,
  parameter int RED  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    up_valid,
  output logic                                    up_ready,
  input  logic [(1<<IN_L)-1:0][DW-1:0]            up_data,
  input  logic [IN_L-1:0]                         up_rem,
  input  logic [SW-1:0]                           up_sel,
  input  logic                                    up_err,
  output logic                                    dn_valid,
  input  logic                                    dn_ready,
  output logic [(1<<(IN_L-RED))-1:0][DW-1:0]      dn_data,
  output logic [width_min1(IN_L-RED)-1:0]         dn_rem,
  output logic [SW-1:0]                           dn_sel,
  output logic                                    dn_err
);

  localparam int OUT_L   = IN_L - RED;
  localparam int CNT_OUT = 1 << OUT_L;
  localparam int ROW     = width_min1(OUT_L);

  logic [CNT_OUT-1:0][DW-1:0] red_s;
  logic [ROW-1:0]             rem_s;
  stage_ctl_t                 ctl_r;
  logic [CNT_OUT-1:0][DW-1:0] data_r;
  logic [ROW-1:0]             rem_r;
  logic [SW-1:0]              sel_r;

  // Survivor j is the input whose index is {j, low RED bits of the remaining sel}
  always_comb begin
    red_s = '0;
    for (int j = 0; j < CNT_OUT; j++) begin
      red_s[j] = up_data[IN_L'(j << RED) | IN_L'(up_rem[RED-1:0])];
    end
  end

  if (OUT_L > 0) begin : g_rem
    assign rem_s = up_rem[IN_L-1:RED];
  end else begin : g_norem
    assign rem_s = 1'b0;
  end

  // An empty stage, or one whose contents leave this cycle, can take new data
  assign up_ready = ~ctl_r.valid | dn_ready;

  // Payload register; data fields only move when a real transfer lands here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_r  <= '0;
      data_r <= '0;
      rem_r  <= '0;
      sel_r  <= '0;
    end else if (up_ready) begin
      ctl_r.valid <= up_valid;
      if (up_valid) begin
        ctl_r.err <= up_err;
        data_r    <= red_s;
        rem_r     <= rem_s;
        sel_r     <= up_sel;
      end
    end
  end

  assign dn_valid = ctl_r.valid;
  assign dn_err   = ctl_r.err;
  assign dn_data  = data_r;
  assign dn_rem   = rem_r;
  assign dn_sel   = sel_r;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 WIDTH-bit selector tree with valid/ready backpressure.
// Optional MUX_TREE_PARITY_EN adds i_par / out_par_err carried alongside the data.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int N          = 32,
  parameter int STAGE_LVLS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0][WIDTH-1:0]      i,
  input  logic [clog2_min1(N)-1:0]     sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out,
  output logic [clog2_min1(N)-1:0]     out_sel,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef MUX_TREE_PARITY_EN
  ,
  input  logic [N-1:0]                 i_par,
  output logic                         out_par_err
`endif
);

  localparam int LVLS = clog2_min1(N);
  localparam int SW   = LVLS;
  localparam int LAT  = stage_count(LVLS, STAGE_LVLS);
  localparam int NP   = 1 << LVLS;
  localparam int NW   = SW + 1;
`ifdef MUX_TREE_PARITY_EN
  localparam int DW   = WIDTH + 1;
`else
  localparam int DW   = WIDTH;
`endif

  logic [NP-1:0][DW-1:0] pad_s;
  logic                  err_s;
  logic [LAT:0]          vld_s;
  logic [LAT:0]          rdy_s;
  logic [LAT:0][SW-1:0]  sel_l;
  logic [LAT:0]          err_l;
  logic [DW-1:0]         last_s;

  // Zero-padding to a full power-of-two tree makes out-of-range sel produce zero data
  always_comb begin
    pad_s = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MUX_TREE_PARITY_EN
      pad_s[k] = {i_par[k], i[k]};
`else
      pad_s[k] = i[k];
`endif
    end
  end

  assign err_s    = ({1'b0, sel} >= NW'(N));
  assign vld_s[0] = in_valid;
  assign sel_l[0] = sel;
  assign err_l[0] = err_s;
  assign rdy_s[LAT] = out_ready;
  assign in_ready = rdy_s[0];

  for (genvar s = 0; s < LAT; s++) begin : g_st
    localparam int IN_L  = LVLS - s * STAGE_LVLS;
    localparam int RED   = (IN_L < STAGE_LVLS) ? IN_L : STAGE_LVLS;
    localparam int OUT_L = IN_L - RED;

    logic [(1<<IN_L)-1:0][DW-1:0]  up_data_s;
    logic [IN_L-1:0]               up_rem_s;
    logic [(1<<OUT_L)-1:0][DW-1:0] dn_data_s;
    logic [width_min1(OUT_L)-1:0]  dn_rem_s;

    if (s == 0) begin : g_head
      assign up_data_s = pad_s;
      assign up_rem_s  = sel;
    end else begin : g_link
      assign up_data_s = g_st[s-1].dn_data_s;
      assign up_rem_s  = g_st[s-1].dn_rem_s;
    end

    mux_tree_stage #(
      .DW   (DW),
      .SW   (SW),
      .IN_L (IN_L),
      .RED  (RED)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_valid (vld_s[s]),
      .up_ready (rdy_s[s]),
      .up_data  (up_data_s),
      .up_rem   (up_rem_s),
      .up_sel   (sel_l[s]),
      .up_err   (err_l[s]),
      .dn_valid (vld_s[s+1]),
      .dn_ready (rdy_s[s+1]),
      .dn_data  (dn_data_s),
      .dn_rem   (dn_rem_s),
      .dn_sel   (sel_l[s+1]),
      .dn_err   (err_l[s+1])
    );
  end

  assign last_s    = g_st[LAT-1].dn_data_s[0];
  assign out       = last_s[WIDTH-1:0];
  assign out_sel   = sel_l[LAT];
  assign out_err   = err_l[LAT];
  assign out_valid = vld_s[LAT];

`ifdef MUX_TREE_PARITY_EN
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  assign out_par_err = out_valid & parity_mismatch(last_s[WIDTH-1:0], last_s[WIDTH]);
`endif

endmodule
